// File: rtl/regfile_sb.sv
// Dual-bank (integer/float) register file with NREAD read ports, NWRITE write-back
// ports and a per-register busy scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_sb #(
    parameter int W      = 32,
    parameter int AW     = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD-1:0]      rd_fmode,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*W-1:0]    rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  iss_en,
    input  logic                  iss_fmode,
    input  logic [AW-1:0]         iss_addr,
    input  logic [NWRITE-1:0]     wr_en,
    input  logic [NWRITE-1:0]     wr_fmode,
    input  logic [NWRITE*AW-1:0]  wr_addr,
    input  logic [NWRITE*W-1:0]   wr_data,
    output logic [AW+1:0]         busy_cnt
);

    localparam int NREG = 2 ** AW;

    logic [W-1:0]    int_q [NREG];
    logic [W-1:0]    int_d [NREG];
    logic [W-1:0]    flt_q [NREG];
    logic [W-1:0]    flt_d [NREG];
    logic [NREG-1:0] int_busy_q, int_busy_d;
    logic [NREG-1:0] flt_busy_q, flt_busy_d;
    logic [AW+1:0]   busy_cnt_q, busy_cnt_d;
    logic [AW-1:0]   ra_s [NREAD];

    function automatic logic [AW+1:0] popcnt(input logic [2*NREG-1:0] v);
        logic [AW+1:0] c;
        c = '0;
        for (int k = 0; k < 2 * NREG; k++) begin
            c = c + {{(AW + 1){1'b0}}, v[k]};
        end
        return c;
    endfunction

    for (genvar g = 0; g < NREAD; g++) begin : g_ra
        assign ra_s[g] = rd_addr[g*AW +: AW];
    end

    // Next-state: ascending port order gives the highest-index writer priority;
    // issue is applied after write-back so a same-cycle reservation wins.
    always_comb begin
        int_d      = int_q;
        flt_d      = flt_q;
        int_busy_d = int_busy_q;
        flt_busy_d = flt_busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j]) begin
                if (wr_fmode[j]) begin
                    flt_d[wr_addr[j*AW +: AW]]      = wr_data[j*W +: W];
                    flt_busy_d[wr_addr[j*AW +: AW]] = 1'b0;
                end else if (wr_addr[j*AW +: AW] != '0) begin
                    int_d[wr_addr[j*AW +: AW]]      = wr_data[j*W +: W];
                    int_busy_d[wr_addr[j*AW +: AW]] = 1'b0;
                end else begin
                    int_d[0] = '0;
                end
            end else begin
                int_d[0] = '0;
            end
        end
        if (iss_en) begin
            if (iss_fmode) begin
                flt_busy_d[iss_addr] = 1'b1;
            end else begin
                int_busy_d[iss_addr] = 1'b1;
            end
        end else begin
            int_busy_d[0] = 1'b0;
        end
        int_busy_d[0] = 1'b0;
        int_d[0]      = '0;
        busy_cnt_d    = popcnt({flt_busy_d, int_busy_d});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                int_q[k] <= '0;
                flt_q[k] <= '0;
            end
            int_busy_q <= '0;
            flt_busy_q <= '0;
            busy_cnt_q <= '0;
        end else begin
            int_q      <= int_d;
            flt_q      <= flt_d;
            int_busy_q <= int_busy_d;
            flt_busy_q <= flt_busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Combinational read ports; integer register 0 is forced to zero and never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_fmode[i]) begin
                rd_data[i*W +: W] = flt_q[ra_s[i]];
                rd_busy[i]        = flt_busy_q[ra_s[i]];
            end else begin
                rd_data[i*W +: W] = int_q[ra_s[i]];
                rd_busy[i]        = int_busy_q[ra_s[i]];
            end
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_en[j] && (wr_fmode[j] == rd_fmode[i]) && (wr_addr[j*AW +: AW] == ra_s[i])) begin
                    rd_data[i*W +: W] = wr_data[j*W +: W];
                    rd_busy[i]        = iss_en && (iss_fmode == rd_fmode[i]) && (iss_addr == ra_s[i]);
                end else begin
                    rd_busy[i] = rd_busy[i];
                end
            end
`else
            rd_busy[i] = rd_busy[i];
`endif
            if (!rd_fmode[i] && (ra_s[i] == '0)) begin
                rd_data[i*W +: W] = '0;
                rd_busy[i]        = 1'b0;
            end else begin
                rd_busy[i] = rd_busy[i];
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (both with and without REGFILE_BYPASS_EN).
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   rd_fmode;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*W-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            iss_en;
    logic            iss_fmode;
    logic [AW-1:0]   iss_addr;
    logic [NW-1:0]   wr_en;
    logic [NW-1:0]   wr_fmode;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*W-1:0] wr_data;
    logic [AW+1:0]   busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.W(W), .AW(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk(clk), .rst(rst),
        .rd_fmode(rd_fmode), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_en(iss_en), .iss_fmode(iss_fmode), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_fmode(wr_fmode), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_en = 1'b0;
        wr_en  = '0;
    endtask

    task automatic rd(input int p, input logic f, input logic [AW-1:0] a);
        rd_fmode[p]       = f;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input int p, input logic f, input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en[p]            = 1'b1;
        wr_fmode[p]         = f;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*W +: W]   = d;
    endtask

    task automatic iss(input logic f, input logic [AW-1:0] a);
        iss_en    = 1'b1;
        iss_fmode = f;
        iss_addr  = a;
    endtask

    initial begin
        rst = 1'b1; rd_fmode = '0; rd_addr = '0; iss_en = 1'b0; iss_fmode = 1'b0;
        iss_addr = '0; wr_en = '0; wr_fmode = '0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        rst = 1'b0;
        rd(0, 1'b0, 5'd1); rd(1, 1'b1, 5'd1);
        #1;
        check("reset_cnt", 64'(busy_cnt), 64'd0);
        check("reset_int1", 64'(rd_data[0 +: W]), 64'd0);

        // reset clears data, busy, and discards same-cycle write/issue
        wr(0, 1'b1, 5'd3, 32'hDEADBEEF); iss(1'b0, 5'd4);
        tick(); idle();
        rd(0, 1'b1, 5'd3); rd(1, 1'b0, 5'd4); #1;
        check("pre_rst_f3", 64'(rd_data[0 +: W]), 64'hDEADBEEF);
        check("pre_rst_busy", 64'(rd_busy[1]), 64'd1);
        check("pre_rst_cnt", 64'(busy_cnt), 64'd1);
        rst = 1'b1; wr(0, 1'b1, 5'd3, 32'h11111111); iss(1'b1, 5'd6);
        tick(); rst = 1'b0; idle();
        rd(1, 1'b1, 5'd6); #1;
        check("rst_f3", 64'(rd_data[0 +: W]), 64'd0);
        check("rst_cnt", 64'(busy_cnt), 64'd0);
        check("rst_f6_busy", 64'(rd_busy[1]), 64'd0);

        // integer register 0
        wr(0, 1'b0, 5'd0, 32'h12345678); iss(1'b0, 5'd0);
        rd(0, 1'b0, 5'd0); #1;
        check("z_same_data", 64'(rd_data[0 +: W]), 64'd0);
        tick(); idle(); #1;
        check("z_data", 64'(rd_data[0 +: W]), 64'd0);
        check("z_busy", 64'(rd_busy[0]), 64'd0);
        check("z_cnt", 64'(busy_cnt), 64'd0);

        // bank separation
        wr(0, 1'b0, 5'd5, 32'hA5); wr(1, 1'b1, 5'd5, 32'h3F800000);
        tick(); idle();
        rd(0, 1'b0, 5'd5); rd(1, 1'b1, 5'd5); #1;
        check("bank_int5", 64'(rd_data[0 +: W]), 64'hA5);
        check("bank_flt5", 64'(rd_data[W +: W]), 64'h3F800000);

        // write collision: port 1 wins
        wr(0, 1'b0, 5'd7, 32'h1); wr(1, 1'b0, 5'd7, 32'h2);
        tick(); idle();
        rd(0, 1'b0, 5'd7); #1;
        check("coll_int7", 64'(rd_data[0 +: W]), 64'h2);

        // scoreboard on int 9
        iss(1'b0, 5'd9); rd(0, 1'b0, 5'd9);
        tick(); idle(); #1;
        check("sb_busy_t1", 64'(rd_busy[0]), 64'd1);
        check("sb_cnt_t1", 64'(busy_cnt), 64'd1);
        tick(); tick();
        check("sb_busy_t3", 64'(rd_busy[0]), 64'd1);
        wr(1, 1'b0, 5'd9, 32'h55);
        tick(); idle(); #1;
        check("sb_busy_t4", 64'(rd_busy[0]), 64'd0);
        check("sb_cnt_t4", 64'(busy_cnt), 64'd0);
        check("sb_data_t4", 64'(rd_data[0 +: W]), 64'h55);
        iss(1'b0, 5'd9); wr(0, 1'b0, 5'd9, 32'h77);
        tick(); idle(); #1;
        check("sb_same_busy", 64'(rd_busy[0]), 64'd1);
        check("sb_same_cnt", 64'(busy_cnt), 64'd1);
        check("sb_same_data", 64'(rd_data[0 +: W]), 64'h77);
        wr(0, 1'b0, 5'd9, 32'h88);
        tick(); idle(); #1;
        check("sb_clr_cnt", 64'(busy_cnt), 64'd0);

        // float 0 is normal; re-issue keeps count
        iss(1'b1, 5'd0); rd(1, 1'b1, 5'd0);
        tick(); #1;
        check("f0_busy", 64'(rd_busy[1]), 64'd1);
        check("f0_cnt", 64'(busy_cnt), 64'd1);
        tick(); iss(1'b0, 5'd3);
        tick(); idle(); #1;
        check("reiss_cnt", 64'(busy_cnt), 64'd2);
        wr(0, 1'b1, 5'd0, 32'hF0); wr(1, 1'b0, 5'd3, 32'h33);
        tick(); idle(); #1;
        check("wb2_cnt", 64'(busy_cnt), 64'd0);
        check("f0_data", 64'(rd_data[W +: W]), 64'hF0);

        // bypass / latency on float 2
        wr(0, 1'b1, 5'd2, 32'h11);
        tick(); idle();
        wr(0, 1'b1, 5'd2, 32'h40490FDB); rd(1, 1'b1, 5'd2); rd(0, 1'b0, 5'd0); wr(1, 1'b0, 5'd0, 32'hBAD); #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same", 64'(rd_data[W +: W]), 64'h40490FDB);
`else
        check("byp_same", 64'(rd_data[W +: W]), 64'h11);
`endif
        check("byp_int0", 64'(rd_data[0 +: W]), 64'd0);
        tick(); idle(); #1;
        check("byp_next", 64'(rd_data[W +: W]), 64'h40490FDB);
        iss(1'b1, 5'd2);
        tick(); idle();
        wr(0, 1'b1, 5'd2, 32'h7); #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_busy", 64'(rd_busy[1]), 64'd0);
`else
        check("byp_busy", 64'(rd_busy[1]), 64'd1);
`endif
        iss(1'b1, 5'd2); #1;
        check("byp_busy_iss", 64'(rd_busy[1]), 64'd1);
        tick(); idle(); #1;
        check("byp_reiss", 64'(rd_busy[1]), 64'd1);
        wr(0, 1'b1, 5'd2, 32'h8);
        tick(); idle(); #1;
        check("byp_clr_cnt", 64'(busy_cnt), 64'd0);

        // fill every register: count saturates at 63
        for (int k = 0; k < 64; k++) begin
            iss(k[5], k[4:0]);
            tick();
        end
        idle(); #1;
        check("max_cnt", 64'(busy_cnt), 64'd63);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check("max_rst_cnt", 64'(busy_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
